fp_mul_issue_queue: RTL and testbench

//  Upstream feeder for the single-precision FP multiplier. Buffers operand pairs
//  in a small FIFO and issues one pair at a time on the multiplier's in_rdy/res_rdy

---
 rtl/fp_mul_pkg.sv | 15 +
 rtl/fp_mul_operand_fifo.sv | 56 +++++
 rtl/fp_mul_issue_queue.sv | 131 +++++++++++++
 tb/tb_fp_mul_issue_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared constants and FSM encodings for the FP multiplier issue queue.
// Holds the IEEE-754 single-precision field widths and the canonical quiet NaN.
package fp_mul_pkg;

  localparam int          FP_EXP_W = 8;
  localparam int          FP_MAN_W = 23;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/fp_mul_operand_fifo.sv
// Operand-pair FIFO: DEPTH entries of W bits, head shows the oldest entry.
// Push is ignored when full and pop is ignored when empty.
module fp_mul_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_issue_queue.sv
// Issue queue in front of the FP multiplier: buffers operand pairs, issues one at a
// time, holds operands during the operation and registers the result. FP_MUL_WDOG_EN adds a watchdog.
module fp_mul_issue_queue
  import fp_mul_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_op1,
  input  logic [DATA_W-1:0]          in_op2,
  output logic [DATA_W-1:0]          mul_op1,
  output logic [DATA_W-1:0]          mul_op2,
  output logic                       mul_in_rdy,
  input  logic [DATA_W-1:0]          mul_res,
  input  logic                       mul_res_rdy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_res,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     level,
  output logic [1:0]                 dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and data is held stable while valid is high and not taken.

  fsm_state_e          state;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*DATA_W-1:0] fifo_head;
  logic                push;
  logic                issue;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign issue     = (state == ST_IDLE) && !fifo_empty && (!out_valid || out_ready);
  assign dbg_state = state;

  fp_mul_operand_fifo #(
    .DEPTH (DEPTH),
    .W     (2*DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .data  ({in_op1, in_op2}),
    .pop   (issue),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

`ifdef FP_MUL_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             out_err_q;
  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mul_op1    <= '0;
      mul_op2    <= '0;
      mul_in_rdy <= 1'b0;
      out_valid  <= 1'b0;
      out_res    <= '0;
`ifdef FP_MUL_WDOG_EN
      out_err_q  <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            mul_op1    <= fifo_head[2*DATA_W-1:DATA_W];
            mul_op2    <= fifo_head[DATA_W-1:0];
            mul_in_rdy <= 1'b1;
            state      <= ST_WAIT;
`ifdef FP_MUL_WDOG_EN
            wd_cnt     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          // Issue is gated on the output register, so a capture never overwrites un-acked data.
          if (mul_res_rdy) begin
            out_res    <= mul_res;
            out_valid  <= 1'b1;
            mul_in_rdy <= 1'b0;
            state      <= ST_IDLE;
`ifdef FP_MUL_WDOG_EN
            out_err_q  <= 1'b0;
          end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            out_res    <= DATA_W'(FP_QNAN);
            out_err_q  <= 1'b1;
            out_valid  <= 1'b1;
            mul_in_rdy <= 1'b0;
            state      <= ST_DRAIN;
            wd_cnt     <= '0;
          end else begin
            wd_cnt     <= wd_cnt + 1'b1;
`endif
          end
        end
`ifdef FP_MUL_WDOG_EN
        ST_DRAIN: begin
          // A late result from the aborted operation is swallowed here.
          if (mul_res_rdy || (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state  <= ST_IDLE;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_issue_queue.sv
// Bench for fp_mul_issue_queue: queue-based reference model, multiplier model and
// randomized stimulus, with directed sequences for latency, backpressure and reset.
module tb_fp_mul_issue_queue;
  import fp_mul_pkg::*;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_op1, in_op2;
  logic [DATA_W-1:0] mul_op1, mul_op2;
  logic              mul_in_rdy;
  logic [DATA_W-1:0] mul_res;
  logic              mul_res_rdy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_res;
  logic              out_err;
  logic [LW-1:0]     level;
  logic [1:0]        dbg_state;

  fp_mul_issue_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_in_rdy(mul_in_rdy), .mul_res(mul_res), .mul_res_rdy(mul_res_rdy),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_err(out_err), .level(level), .dbg_state(dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic [63:0]       mq[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                m_wait, m_drain, m_in_rdy, m_out_valid, m_out_err;
  logic [31:0]       m_op1, m_op2, m_out_res;
  int                m_wcnt;

  // multiplier model state
  bit          mbusy;
  int          mcnt;
  int          mdelay_lo = 2;
  int          mdelay_hi = 8;
  bit          stale_pulse;
  logic [31:0] mop1, mop2;
  int          pulse_cyc = -100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stand-in multiplier: exact for 1.0*x, an arbitrary fixed bit function otherwise
  function automatic logic [31:0] mul_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000) return b;
    return a + b * 32'd3;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_wait = 0; m_drain = 0; m_in_rdy = 0; m_out_valid = 0; m_out_err = 0;
    m_op1 = '0; m_op2 = '0; m_out_res = '0; m_wcnt = 0;
    mbusy = 0; mcnt = 0;
  endtask

  task automatic compare();
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("level", level, mq.size());
    chk("out_valid", out_valid, m_out_valid);
    if (m_out_valid) begin
      chk("out_res", out_res, m_out_res);
      chk("out_err", out_err, m_out_err);
    end
    chk("mul_in_rdy", mul_in_rdy, m_in_rdy);
    if (m_in_rdy) chk("mul_op", {mul_op1, mul_op2}, {m_op1, m_op2});
  endtask

  // one clock: scoreboard, multiplier response, model advance, then compare
  task automatic step();
    bit push, issue, cap, acc;
    int sz;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_result", out_res, 64'hDEAD);
      else chk("sb_res", out_res, exp_q.pop_front());
    end
    mul_res_rdy = 1'b0;
    mul_res     = $urandom;
    if (stale_pulse) begin
      mul_res_rdy = 1'b1;
      stale_pulse = 0;
    end else if (!rst) begin
      if (!mbusy && mul_in_rdy) begin
        mbusy = 1; mcnt = $urandom_range(mdelay_hi, mdelay_lo);
        mop1 = mul_op1; mop2 = mul_op2;
      end
      if (mbusy) begin
        chk("op_stable", {mul_op1, mul_op2}, {mop1, mop2});
        if (mcnt <= 1) begin
          mul_res_rdy = 1'b1; mul_res = mul_fn(mop1, mop2);
          mbusy = 0; pulse_cyc = cyc;
        end else mcnt--;
      end
    end
    if (rst) model_reset();
    else begin
      sz    = mq.size();
      push  = in_valid && (sz < DEPTH);
      acc   = m_out_valid && out_ready;
      issue = !m_wait && !m_drain && (sz > 0) && (!m_out_valid || out_ready);
      cap   = m_wait && mul_res_rdy;
      if (acc) m_out_valid = 0;
      if (issue) begin
        {m_op1, m_op2} = mq.pop_front();
        m_in_rdy = 1; m_wait = 1; m_wcnt = 0;
      end else if (cap) begin
        m_out_res = mul_fn(m_op1, m_op2);
        m_out_valid = 1; m_out_err = 0; m_in_rdy = 0; m_wait = 0;
        exp_q.push_back(m_out_res);
      end
`ifdef FP_MUL_WDOG_EN
      else if (m_wait) begin
        m_wcnt++;
        if (m_wcnt == TIMEOUT) begin
          m_out_res = FP_QNAN; m_out_err = 1; m_out_valid = 1; m_in_rdy = 0;
          m_wait = 0; m_drain = 1; m_wcnt = 0;
          exp_q.push_back(FP_QNAN);
        end
      end else if (m_drain) begin
        m_wcnt++;
        if (mul_res_rdy || m_wcnt == TIMEOUT) m_drain = 0;
      end
`endif
      if (push) mq.push_back({in_op1, in_op2});
    end
    @(negedge clk);
    cyc++;
    compare();
  endtask

  // driver: hold a pair on the input until the model says it was taken
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input int max_wait);
    bit done;
    done = 0;
    in_valid = 1'b1; in_op1 = a; in_op2 = b;
    for (int i = 0; i < max_wait && !done; i++) begin
      done = (mq.size() < DEPTH);
      step();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max_c);
    bit idle;
    idle = 0;
    for (int i = 0; i < max_c && !idle; i++) begin
      step();
      idle = (mq.size() == 0) && !m_wait && !m_drain && !m_out_valid;
    end
    if (!idle) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0;
    out_ready = 1'b0; mul_res = '0; mul_res_rdy = 1'b0; stale_pulse = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_in_rdy", mul_in_rdy, 0);
    chk("rst_mul_ops", {mul_op1, mul_op2}, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 * 2.0 with a 12-cycle multiplier
    mdelay_lo = 12; mdelay_hi = 12; out_ready = 1'b1;
    in_valid = 1'b1; in_op1 = 32'h3F80_0000; in_op2 = 32'h4000_0000;
    step();
    in_valid = 1'b0;
    chk("t1_level_after_push", level, 1);
    chk("t1_no_issue_yet", mul_in_rdy, 0);
    step();
    chk("t1_issue_2_edges", mul_in_rdy, 1);
    chk("t1_mul_op1", mul_op1, 32'h3F80_0000);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (out_valid) begin
        seen = 1;
        chk("t1_out_res", out_res, 32'h4000_0000);
        chk("t1_res_latency", cyc - pulse_cyc, 1);
      end
    end
    if (!seen) chk("t1_result_timeout", 0, 1);
    wait_idle(50);

    // back-to-back pushes fill the FIFO while the multiplier is slow
    mdelay_lo = 20; mdelay_hi = 20;
    for (int i = 0; i < 5; i++) push_pair($urandom, $urandom, 10);
    chk("t2_full_level", level, DEPTH);
    chk("t2_full_in_ready", in_ready, 0);
    push_pair($urandom, $urandom, 60);
    mdelay_lo = 2; mdelay_hi = 8;
    wait_idle(200);

    // backpressure withholds the second issue; then push+pop at level 2
    out_ready = 1'b0; mdelay_lo = 3; mdelay_hi = 3;
    push_pair($urandom, $urandom, 5);
    push_pair($urandom, $urandom, 5);
    repeat (20) step();
    chk("t3_held_valid", out_valid, 1);
    chk("t3_no_second_issue", mul_in_rdy, 0);
    chk("t3_level", level, 1);
    push_pair($urandom, $urandom, 5);
    chk("t6_level_before", level, 2);
    out_ready = 1'b1; in_valid = 1'b1; in_op1 = $urandom; in_op2 = $urandom;
    step();
    in_valid = 1'b0;
    chk("t6_level_push_pop", level, 2);
    mdelay_lo = 2; mdelay_hi = 8;
    wait_idle(100);

    // reset while waiting on the multiplier, then a stale pulse
    mdelay_lo = 30; mdelay_hi = 30;
    push_pair($urandom, $urandom, 5);
    for (int i = 0; i < 5 && !m_in_rdy; i++) step();
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("t4_level", level, 0);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_mul_in_rdy", mul_in_rdy, 0);
    rst = 1'b0;
    stale_pulse = 1;
    step();
    step();
    chk("t4_stale_ignored", out_valid, 0);
    mdelay_lo = 2; mdelay_hi = 8;

`ifdef FP_MUL_WDOG_EN
    // silent multiplier triggers the watchdog; its late pulse lands in DRAIN
    mdelay_lo = TIMEOUT + 5; mdelay_hi = TIMEOUT + 5;
    push_pair($urandom, $urandom, 5);
    seen = 0;
    for (int i = 0; i < 3 * TIMEOUT && !seen; i++) begin
      step();
      if (out_valid) begin
        seen = 1;
        chk("t5_qnan", out_res, 32'h7FC0_0000);
        chk("t5_err", out_err, 1);
      end
    end
    if (!seen) chk("t5_timeout_missing", 0, 1);
    repeat (20) step();
    chk("t5_late_discarded", out_valid, 0);
    mdelay_lo = 2; mdelay_hi = 8;
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(1, 0) == 1);
      in_op1    = $urandom;
      in_op2    = $urandom;
      out_ready = ($urandom_range(9, 0) < 7);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
